i2c_target_ctrl: RTL and testbench
==================================

I2C_TARGET_CTRL -- requirements
Module: i2c_target_ctrl

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h4A, 7-bit I2C target address matched after START.
REQ-002 Parameter REG_PTR_W, default 8, register pointer width; the pointer wraps at 2**REG_PTR_W.
REQ-003 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Ports sda_in and scl_in, input, 1 each: SDA/SCL levels, already two-flop synchronized to clk.
REQ-006 Ports past_sda_in and past_scl_in, input, 1 each: the above delayed by one clk, used for edge detection.
REQ-007 Port sda_oe, output, 1: 1 pulls SDA low (open-drain); 0 releases SDA.
REQ-008 Port wr_en, output, 1: single-cycle register write strobe.
REQ-009 Ports wr_addr, output, REG_PTR_W, and wr_data, output, 8: write address and data, valid while wr_en=1.
REQ-010 Port rd_addr, output, REG_PTR_W: current read address.
REQ-011 Port rd_data, input, 8: register value at rd_addr, combinational, valid one clk after rd_addr changes.
REQ-012 Port busy, output, 1: 1 from an accepted START until STOP or return to IDLE.

Function
REQ-013 Event decode: START = scl_in&past_scl_in & past_sda_in&~sda_in; STOP = scl_in&past_scl_in & ~past_sda_in&sda_in; SCL rise = ~past_scl_in&scl_in; SCL fall = past_scl_in&~scl_in.
REQ-014 SDA sampling: SDA is sampled only on SCL rise, MSB first; sda_oe changes only on SCL fall, START, STOP or reset.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-016 START from any state, including a repeated START, goes to ADDR, clears the bit counter and sets busy=1; the pointer is retained.
REQ-017 STOP from any state goes to IDLE with sda_oe=0 and busy=0; a partially received byte is discarded and no wr_en is issued.
REQ-018 ADDR: after 8 bits, if addr[7:1]==TARGET_ADDR and the R/W bit is permitted (REQ-029), assert sda_oe=1 on the next SCL fall (ADDR_ACK); otherwise go to WAIT_STOP with sda_oe=0.
REQ-019 ACK bit duration: sda_oe is held through the ACK bit's SCL high and released on the following SCL fall, except in RDATA, where bit 7 is driven instead.
REQ-020 Write path: the first byte loads the pointer (PTR, then PTR_ACK, always ACKed); each subsequent byte goes WDATA, then WDATA_ACK.
REQ-021 Write strobe: wr_en pulses for exactly one clk in the cycle after the 8th-bit SCL rise, with wr_addr=pointer and wr_data=byte; the pointer then increments, modulo 2**REG_PTR_W.
REQ-022 Read path: rd_addr=pointer; on entering RDATA, rd_data is latched into a shift register; bit n drives sda_oe=~bit on each SCL fall.
REQ-023 Read continuation: after 8 bits, sda_oe=0 for the master ACK slot, sampled on SCL rise; ACK (0) increments the pointer and returns to RDATA; NACK (1) goes to WAIT_STOP.
REQ-024 WAIT_STOP ignores all SCL edges; only START or STOP exits it.
REQ-025 Simultaneous events: START/STOP take priority over SCL-edge processing in the same cycle.

Reset
REQ-026 While rst=1, the block SHALL be in IDLE with sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, pointer=0 and bit counter=0.
REQ-027 Reset assertion mid-transaction SHALL release SDA immediately, asynchronously.
REQ-028 After reset deasserts, only a START SHALL leave IDLE.

Configuration
REQ-029 Macro I2C_TARGET_READ_EN: when defined, R/W=1 addresses are ACKed and REQ-022/023 apply.
REQ-030 Without I2C_TARGET_READ_EN, R/W=1 is NACKed (go to WAIT_STOP), RDATA/RDATA_ACK logic is absent, and rd_addr is tied to 0.

Structure
REQ-031 Package i2c_pkg SHALL hold the FSM state enum typedef, I2C_ADDR_W=7, I2C_BYTE_W=8, and the START/STOP event typedef.
REQ-032 Sub-module i2c_edge_det SHALL decode START, STOP, SCL rise and SCL fall from the four input levels; the FSM resides in i2c_target_ctrl.

Verification (TARGET_ADDR=0x4A)
REQ-033 Reset: assert rst mid-byte -> sda_oe=0, busy=0, wr_en never pulses.
REQ-034 Write: START, 0x94, 0x03, 0xA5, 0x5A, STOP -> four ACKs; wr_en pulses (0x03,0xA5) then (0x04,0x5A); busy=0 after STOP.
REQ-035 Wrong address: START, 0x92, 0x11, STOP -> sda_oe stays 0 throughout; no wr_en.
REQ-036 Wrap: pointer 0xFF, data 0x01, 0x02 -> writes to 0xFF then 0x00.
REQ-037 Read (macro defined): START, 0x94, 0x10, Sr, 0x95, rd_data=0x3C then 0xC3, master ACK then NACK -> SDA bytes 0x3C, 0xC3; rd_addr 0x10 then 0x11; SDA released; WAIT_STOP. Without the macro, 0x95 is NACKed.
REQ-038 Abort: STOP after 4 bits of a data byte -> IDLE; no wr_en; next START is accepted normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared types for the I2C register target: FSM state encoding, byte/address
// widths and the decoded bus-event bundle passed from i2c_edge_det to the
// controller FSM.
// -----------------------------------------------------------------------------
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_WAIT_STOP
   } i2c_state_e;

   // One cycle-wide flag per decoded bus event.
   typedef struct packed {
      logic start;
      logic stop;
      logic scl_rise;
      logic scl_fall;
   } i2c_evt_t;

endpackage

// File: rtl/i2c_edge_det.sv
// -----------------------------------------------------------------------------
// i2c_edge_det
// Decodes START, STOP and SCL edges from the synchronized bus levels and their
// one-clock-delayed copies. Purely combinational.
//
// Ports:
//   sda_i, scl_i           current synchronized SDA/SCL levels
//   past_sda_i, past_scl_i the same levels delayed by one clk
//   evt_o                  decoded events (start, stop, scl_rise, scl_fall)
// -----------------------------------------------------------------------------
module i2c_edge_det
   import i2c_pkg::*;
(
   input  logic     sda_i,
   input  logic     scl_i,
   input  logic     past_sda_i,
   input  logic     past_scl_i,
   output i2c_evt_t evt_o
);

   // START/STOP are SDA transitions while SCL is stably high.
   assign evt_o.start    = scl_i & past_scl_i & past_sda_i & ~sda_i;
   assign evt_o.stop     = scl_i & past_scl_i & ~past_sda_i & sda_i;
   assign evt_o.scl_rise = ~past_scl_i & scl_i;
   assign evt_o.scl_fall = past_scl_i & ~scl_i;

endmodule

// File: rtl/i2c_target_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_target_ctrl
// I2C target (slave) that exposes a register file through a pointer byte.
// A write transfer loads the pointer with its first data byte and issues one
// wr_en strobe per following byte; a read transfer (optional) streams
// rd_data from rd_addr = pointer, auto-incrementing on each master ACK.
//
// Configuration macro:
//   I2C_TARGET_READ_EN  defined   -> R/W=1 addresses are ACKed, read path built
//                       undefined -> R/W=1 addresses are NACKed, rd_addr = 0
//
// Parameters:
//   TARGET_ADDR  7-bit address this target answers to
//   REG_PTR_W    register pointer width (wraps at 2**REG_PTR_W)
//
// Ports:
//   clk, rst                  system clock, async active-high reset
//   sda_in, scl_in            synchronized bus levels
//   past_sda_in, past_scl_in  the same delayed by one clk
//   sda_oe                    1 pulls SDA low, 0 releases it
//   wr_en, wr_addr, wr_data   single-cycle register write strobe with payload
//   rd_addr, rd_data          register read address / combinational read data
//   busy                      transaction in progress (START seen, no STOP)
// -----------------------------------------------------------------------------
module i2c_target_ctrl
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h4A,
   parameter int                    REG_PTR_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sda_in,
   input  logic                  scl_in,
   input  logic                  past_sda_in,
   input  logic                  past_scl_in,
   output logic                  sda_oe,
   output logic                  wr_en,
   output logic [REG_PTR_W-1:0]  wr_addr,
   output logic [I2C_BYTE_W-1:0] wr_data,
   output logic [REG_PTR_W-1:0]  rd_addr,
   input  logic [I2C_BYTE_W-1:0] rd_data,
   output logic                  busy
);

   localparam logic [3:0] BITS_PER_BYTE = 4'(I2C_BYTE_W);

   i2c_evt_t                evt;
   i2c_state_e              state_q;
   logic [REG_PTR_W-1:0]    ptr_q;
   logic [3:0]              bit_cnt_q;
   logic [I2C_BYTE_W-1:0]   shift_q;

   logic [I2C_BYTE_W-1:0]   rx_byte_d;
   logic [REG_PTR_W-1:0]    rx_ptr_d;
   logic [REG_PTR_W-1:0]    ptr_inc_d;
   logic                    addr_ok_d;

   i2c_edge_det u_edge_det (
      .sda_i      (sda_in),
      .scl_i      (scl_in),
      .past_sda_i (past_sda_in),
      .past_scl_i (past_scl_in),
      .evt_o      (evt)
   );

   // Byte as it will look once the bit on SDA right now is shifted in (MSB first).
   assign rx_byte_d = {shift_q[I2C_BYTE_W-2:0], sda_in};
   assign rx_ptr_d  = REG_PTR_W'(rx_byte_d);
   assign ptr_inc_d = ptr_q + REG_PTR_W'(1);

`ifdef I2C_TARGET_READ_EN
   logic rw_q;

   assign addr_ok_d = (rx_byte_d[I2C_BYTE_W-1:1] == TARGET_ADDR);
   assign rd_addr   = ptr_q;
`else
   logic unused_rd_data;

   // Reads are refused, so only write requests (R/W=0) match.
   assign addr_ok_d      = (rx_byte_d[I2C_BYTE_W-1:1] == TARGET_ADDR) && !rx_byte_d[0];
   assign rd_addr        = '0;
   assign unused_rd_data = ^rd_data;
`endif

   // NOTE: all state below is updated with non-blocking assignments so every
   // branch sees the pre-edge values; later assignments in a branch override
   // earlier defaults within the same clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         sda_oe    <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         busy      <= 1'b0;
`ifdef I2C_TARGET_READ_EN
         rw_q      <= 1'b0;
`endif
      end else begin
         wr_en <= 1'b0;

         // Bus conditions outrank any SCL edge seen in the same cycle.
         if (evt.start) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b1;
         end else if (evt.stop) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state_q)
               // Receive states: shift on SCL rise, decide on the 8th bit,
               // drive ACK on the SCL fall that follows it.
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  if (evt.scl_rise && (bit_cnt_q != BITS_PER_BYTE)) begin
                     shift_q   <= rx_byte_d;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                        case (state_q)
                           ST_ADDR: begin
                              if (!addr_ok_d) state_q <= ST_WAIT_STOP;
`ifdef I2C_TARGET_READ_EN
                              rw_q <= rx_byte_d[0];
`endif
                           end
                           ST_PTR: ptr_q <= rx_ptr_d;
                           default: begin
                              wr_en   <= 1'b1;
                              wr_addr <= ptr_q;
                              wr_data <= rx_byte_d;
                              ptr_q   <= ptr_inc_d;
                           end
                        endcase
                     end
                  end else if (evt.scl_fall && (bit_cnt_q == BITS_PER_BYTE)) begin
                     sda_oe    <= 1'b1;
                     bit_cnt_q <= '0;
                     case (state_q)
                        ST_ADDR: state_q <= ST_ADDR_ACK;
                        ST_PTR:  state_q <= ST_PTR_ACK;
                        default: state_q <= ST_WDATA_ACK;
                     endcase
                  end
               end

               // ACK is held through the ACK bit's SCL high and released on
               // the next fall, which also starts the following byte.
               ST_ADDR_ACK: begin
                  if (evt.scl_fall) begin
                     sda_oe    <= 1'b0;
                     bit_cnt_q <= '0;
                     state_q   <= ST_PTR;
`ifdef I2C_TARGET_READ_EN
                     if (rw_q) begin
                        state_q <= ST_RDATA;
                        shift_q <= rd_data;
                        sda_oe  <= ~rd_data[I2C_BYTE_W-1];
                     end
`endif
                  end
               end

               ST_PTR_ACK, ST_WDATA_ACK: begin
                  if (evt.scl_fall) begin
                     sda_oe    <= 1'b0;
                     bit_cnt_q <= '0;
                     state_q   <= ST_WDATA;
                  end
               end

`ifdef I2C_TARGET_READ_EN
               // Transmit: the MSB is already on the bus when RDATA is entered;
               // each later fall presents the next bit, the 8th fall frees SDA
               // for the master's ACK.
               ST_RDATA: begin
                  if (evt.scl_rise && (bit_cnt_q != BITS_PER_BYTE)) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (evt.scl_fall && (bit_cnt_q == BITS_PER_BYTE)) begin
                     sda_oe    <= 1'b0;
                     bit_cnt_q <= '0;
                     state_q   <= ST_RDATA_ACK;
                  end else if (evt.scl_fall && (bit_cnt_q != 4'd0)) begin
                     shift_q <= {shift_q[I2C_BYTE_W-2:0], 1'b0};
                     sda_oe  <= ~shift_q[I2C_BYTE_W-2];
                  end
               end

               // bit_cnt_q=1 marks "master ACKed"; the pointer moves at the
               // rise so rd_data has settled by the following SCL fall.
               ST_RDATA_ACK: begin
                  if (evt.scl_rise) begin
                     if (sda_in) begin
                        state_q <= ST_WAIT_STOP;
                     end else begin
                        ptr_q     <= ptr_inc_d;
                        bit_cnt_q <= 4'd1;
                     end
                  end else if (evt.scl_fall && (bit_cnt_q == 4'd1)) begin
                     bit_cnt_q <= '0;
                     state_q   <= ST_RDATA;
                     shift_q   <= rd_data;
                     sda_oe    <= ~rd_data[I2C_BYTE_W-1];
                  end
               end
`endif

               // IDLE and WAIT_STOP ignore SCL; only START/STOP leave them.
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_ctrl
// Bit-level I2C master driving i2c_target_ctrl (TARGET_ADDR=0x4A). Expected
// ACKs, register writes and read bytes come from a transaction-level model:
// a pointer variable, a register array and a queue of expected writes.
// Build with +define+I2C_TARGET_READ_EN to exercise the read path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_target_ctrl;

   localparam logic [6:0] TGT = 7'h4A;

   logic       clk = 1'b0;
   logic       rst;
   logic       sda_in, scl_in, past_sda_in, past_scl_in;
   logic       sda_oe, wr_en, busy;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

   logic [7:0]  regs [256];
   int          checks = 0;
   int          errors = 0;
   int          model_ptr = 0;
   logic [15:0] exp_wr_q [$];
   logic [15:0] got_wr_q [$];
   logic [7:0]  tx_data  [$];
   int          oe_hi_cycles = 0;
   int          wr_long = 0;
   logic        wr_en_prev = 1'b0;
   logic        oe_sample;

   assign rd_data = regs[rd_addr];

   always #5 clk = ~clk;

   i2c_target_ctrl #(.TARGET_ADDR(TGT), .REG_PTR_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .sda_in      (sda_in),
      .scl_in      (scl_in),
      .past_sda_in (past_sda_in),
      .past_scl_in (past_scl_in),
      .sda_oe      (sda_oe),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy)
   );

   // Passive monitor on the falling edge: logs writes, strobe width, SDA pulls.
   always @(negedge clk) begin
      if (wr_en) got_wr_q.push_back({wr_addr, wr_data});
      if (wr_en && wr_en_prev) wr_long++;
      wr_en_prev = wr_en;
      if (sda_oe) oe_hi_cycles++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clk of bus time: the sync stage sees the wired-AND of master and target.
   task automatic step(input logic scl, input logic sda_m);
      past_scl_in = scl_in;
      past_sda_in = sda_in;
      scl_in      = scl;
      sda_in      = sda_m & ~sda_oe;
      @(posedge clk);
      #1;
   endtask

   task automatic clk_bit(input logic b);
      repeat (3) step(1'b0, b);
      repeat (2) step(1'b1, b);
      oe_sample = sda_oe;
      step(1'b1, b);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) clk_bit(b[i]);
      clk_bit(1'b1);
      acked = oe_sample;
   endtask

   task automatic recv_byte(input logic master_nack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1);
         b[i] = ~oe_sample;
      end
      clk_bit(master_nack);
   endtask

   task automatic start_cond();
      repeat (2) step(1'b0, 1'b1);
      repeat (3) step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);
   endtask

   task automatic stop_cond();
      repeat (2) step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b1);
   endtask

   // Write transfer of tx_data after a pointer byte; the model decides every ACK.
   task automatic write_txn(input logic [6:0] addr, input logic [7:0] ptr, input string tag);
      logic ack;
      bit   match;
      match = (addr == TGT);
      start_cond();
      check({tag, "_busy_start"}, busy, 1'b1);
      send_byte({addr, 1'b0}, ack);
      check({tag, "_addr_ack"}, ack, match);
      send_byte(ptr, ack);
      check({tag, "_ptr_ack"}, ack, match);
      if (match) model_ptr = ptr;
      foreach (tx_data[i]) begin
         send_byte(tx_data[i], ack);
         check({tag, "_data_ack"}, ack, match);
         if (match) begin
            exp_wr_q.push_back({8'(model_ptr), tx_data[i]});
            model_ptr = (model_ptr + 1) % 256;
         end
      end
      stop_cond();
      check({tag, "_busy_stop"}, busy, 1'b0);
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_wr_count"}, got_wr_q.size(), exp_wr_q.size());
      while (exp_wr_q.size() > 0 && got_wr_q.size() > 0)
         check({tag, "_wr"}, got_wr_q.pop_front(), exp_wr_q.pop_front());
      exp_wr_q.delete();
      got_wr_q.delete();
   endtask

   initial begin
      logic       ack;
      logic [7:0] rb;
      int         oe_base;
      logic [6:0] a;

      rst = 1'b1;
      scl_in = 1'b1; sda_in = 1'b1; past_scl_in = 1'b1; past_sda_in = 1'b1;
      for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("rst_sda_oe",  sda_oe,  1'b0);
      check("rst_busy",    busy,    1'b0);
      check("rst_wr_en",   wr_en,   1'b0);
      check("rst_wr_addr", wr_addr, 8'h00);
      check("rst_wr_data", wr_data, 8'h00);
      check("rst_rd_addr", rd_addr, 8'h00);
      rst = 1'b0;
      repeat (2) step(1'b1, 1'b1);

      // Basic write: (0x03,A5) then (0x04,5A).
      tx_data = '{8'hA5, 8'h5A};
      write_txn(TGT, 8'h03, "write");
      compare_writes("write");

      // Wrong address (0x92): target never touches SDA.
      oe_base = oe_hi_cycles;
      tx_data = '{};
      write_txn(7'h49, 8'h11, "wrong_addr");
      check("wrong_addr_oe_cycles", oe_hi_cycles - oe_base, 0);
      compare_writes("wrong_addr");

      // Pointer wrap: 0xFF then 0x00.
      tx_data = '{8'h01, 8'h02};
      write_txn(TGT, 8'hFF, "wrap");
      compare_writes("wrap");

      // Abort: STOP after 4 data bits discards the byte.
      start_cond();
      send_byte(8'h94, ack);
      check("abort_addr_ack", ack, 1'b1);
      send_byte(8'h20, ack);
      model_ptr = 8'h20;
      for (int i = 0; i < 4; i++) clk_bit(1'($urandom));
      stop_cond();
      check("abort_busy", busy, 1'b0);
      check("abort_sda_oe", sda_oe, 1'b0);
      compare_writes("abort");
      tx_data = '{8'h77};
      write_txn(TGT, 8'h30, "after_abort");
      compare_writes("after_abort");

      // Read path (or its refusal) after a pointer set to 0x10.
      regs[8'h10] = 8'h3C;
      regs[8'h11] = 8'hC3;
      start_cond();
      send_byte(8'h94, ack);
      send_byte(8'h10, ack);
      model_ptr = 8'h10;
      start_cond();
      check("rd_sr_busy", busy, 1'b1);
      send_byte(8'h95, ack);
`ifdef I2C_TARGET_READ_EN
      check("rd_addr_ack", ack, 1'b1);
      check("rd_addr0", rd_addr, 8'(model_ptr));
      recv_byte(1'b0, rb);
      check("rd_byte0", rb, regs[model_ptr]);
      model_ptr = (model_ptr + 1) % 256;
      check("rd_addr1", rd_addr, 8'(model_ptr));
      recv_byte(1'b1, rb);
      check("rd_byte1", rb, regs[model_ptr]);
      check("rd_released", sda_oe, 1'b0);
      check("rd_wait_stop_busy", busy, 1'b1);
      send_byte(8'h94, ack);
      check("rd_wait_stop_ignores", ack, 1'b0);
`else
      check("rd_nack", ack, 1'b0);
      check("rd_nack_busy", busy, 1'b1);
`endif
      stop_cond();
      check("rd_busy_stop", busy, 1'b0);
      compare_writes("read");

      // Randomized write traffic against the model.
      for (int t = 0; t < 20; t++) begin
         a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : TGT;
         tx_data = '{};
         for (int k = 0, n = $urandom_range(0, 3); k < n; k++) tx_data.push_back(8'($urandom));
         write_txn(a, 8'($urandom), "rand");
      end
      compare_writes("rand");

      // Reset while the target holds an ACK: SDA must free without a clock edge.
      start_cond();
      send_byte(8'h94, ack);
      send_byte(8'h40, ack);
      check("arst_pre_oe", sda_oe, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_sda_oe", sda_oe, 1'b0);
      check("arst_busy", busy, 1'b0);
      for (int i = 0; i < 8; i++) clk_bit(1'($urandom));
      rst = 1'b0;
      model_ptr = 0;
      check("arst_rd_addr", rd_addr, 8'h00);

      // Reset mid data byte: no strobe, target idle.
      start_cond();
      send_byte(8'h94, ack);
      send_byte(8'h50, ack);
      for (int i = 0; i < 5; i++) clk_bit(1'($urandom));
      rst = 1'b1;
      repeat (3) step(1'b0, 1'b1);
      rst = 1'b0;
      check("mrst_sda_oe", sda_oe, 1'b0);
      check("mrst_busy", busy, 1'b0);
      repeat (2) step(1'b1, 1'b1);

      // Without a START, a matching address byte is ignored.
      send_byte(8'h94, ack);
      check("nostart_ack", ack, 1'b0);
      check("nostart_busy", busy, 1'b0);
      compare_writes("reset");
      check("wr_en_single_cycle", wr_long, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
